// File: rtl/counter_stim_gen_if.sv
// Bus between the counter stimulus generator, its start control and the counter/scoreboard pair.
interface counter_stim_gen_if;
   logic       start;
   logic       rco_;
   logic       enable_;
   logic [1:0] mode_;
   logic [3:0] D_;
   logic       busy;
   logic       done;
   logic [2:0] phase_;
   logic [7:0] rco_cnt;

   modport master (
      input  start, rco_,
      output enable_, mode_, D_, busy, done, phase_, rco_cnt
   );

   modport slave (
      output start, rco_,
      input  enable_, mode_, D_, busy, done, phase_, rco_cnt
   );
endinterface

// File: rtl/counter_stim_gen.sv
// Phase-sequenced stimulus for the 4-bit multi-mode counter: load/up/load/down/load/+3/hold.
// Optional macro STIM_LOOP_EN: restart straight from DONE while start is held, keeping rco_cnt.
module counter_stim_gen #(
   parameter int unsigned PHASE_LEN = 20,
   parameter logic [3:0]  LFSR_SEED = 4'b1001
) (
   input  logic               clk,
   input  logic               reset,
   counter_stim_gen_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_UP   = 3'd2,
      S_DOWN = 3'd3,
      S_UP3  = 3'd4,
      S_HOLD = 3'd5,
      S_DONE = 3'd6
   } state_t;

   localparam int unsigned PLEN       = (PHASE_LEN == 0) ? 1 : PHASE_LEN;
   localparam logic [7:0]  PHASE_LAST = 8'(PLEN - 1);
   localparam logic [7:0]  HOLD_LAST  = 8'd1;
   localparam logic [3:0]  SEED       = (LFSR_SEED == 4'b0000) ? 4'b0001 : LFSR_SEED;

   state_t     state_q, state_d;
   logic [7:0] phase_cnt_q;
   logic [1:0] load_idx_q;
   logic [3:0] lfsr_q;
   logic       start_accept_c;
   logic       enable_c, busy_c, done_c;
   logic [1:0] mode_c;

   // State register plus the sequencing counters that ride along with it
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         phase_cnt_q <= 8'd0;
         load_idx_q  <= 2'd0;
         lfsr_q      <= SEED;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            phase_cnt_q <= 8'd0;
         else if (state_q inside {S_UP, S_DOWN, S_UP3, S_HOLD})
            phase_cnt_q <= phase_cnt_q + 8'd1;
         if (start_accept_c)
            load_idx_q <= 2'd0;
         else if (state_q == S_LOAD)
            load_idx_q <= load_idx_q + 2'd1;
         if (state_q == S_LOAD)
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      end
   end

   // Next-state logic
   always_comb begin
      state_d        = state_q;
      start_accept_c = 1'b0;
      unique case (state_q)
         S_IDLE: if (bus.start) begin
            state_d        = S_LOAD;
            start_accept_c = 1'b1;
         end
         S_LOAD: begin
            unique case (load_idx_q)
               2'd0:    state_d = S_UP;
               2'd1:    state_d = S_DOWN;
               default: state_d = S_UP3;
            endcase
         end
         S_UP, S_DOWN: if (phase_cnt_q == PHASE_LAST) state_d = S_LOAD;
         S_UP3:        if (phase_cnt_q == PHASE_LAST) state_d = S_HOLD;
         S_HOLD:       if (phase_cnt_q == HOLD_LAST)  state_d = S_DONE;
         S_DONE: begin
`ifdef STIM_LOOP_EN
            if (bus.start) begin
               state_d        = S_LOAD;
               start_accept_c = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode of the state being entered, so registered outputs line up with phase_
   always_comb begin
      enable_c = 1'b0;
      mode_c   = 2'b00;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      unique case (state_d)
         S_LOAD: begin enable_c = 1'b1; mode_c = 2'b11; busy_c = 1'b1; end
         S_UP:   begin enable_c = 1'b1; mode_c = 2'b00; busy_c = 1'b1; end
         S_DOWN: begin enable_c = 1'b1; mode_c = 2'b01; busy_c = 1'b1; end
         S_UP3:  begin enable_c = 1'b1; mode_c = 2'b10; busy_c = 1'b1; end
         S_HOLD: busy_c = 1'b1;
         S_DONE: done_c = 1'b1;
         default: ;
      endcase
   end

   assign bus.phase_ = state_q;

   // Output registers; rco_cnt is only cleared by a start taken from IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.enable_ <= 1'b0;
         bus.mode_   <= 2'b00;
         bus.D_      <= 4'b0000;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.rco_cnt <= 8'd0;
      end else begin
         bus.enable_ <= enable_c;
         bus.mode_   <= mode_c;
         bus.busy    <= busy_c;
         bus.done    <= done_c;
         if (state_d == S_LOAD)
            bus.D_ <= lfsr_q;
         if (start_accept_c && (state_q == S_IDLE))
            bus.rco_cnt <= 8'd0;
         else if (bus.busy && bus.rco_ && (bus.rco_cnt != 8'hFF))
            bus.rco_cnt <= bus.rco_cnt + 8'd1;
      end
   end

endmodule
